// File: rtl/deser_pkg.sv
// Shared definitions for the serial deserializer.
//   state_t    : collection FSM states
//   cnt_width  : width of a counter that must hold values 0..n
package deser_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // A bit counter for an n-bit word has to represent n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/deser_out_stage.sv
// Holding register between the shift stage and the parallel consumer.
// Takes a completed word from the shift stage, presents it on a valid/ready
// interface and pulses overrun when a word arrives but cannot be stored.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   a completed word is offered this cycle (on in_data)
//   in_data    completed word from the shift stage
//   out_ready  consumer accepts when out_valid && out_ready
//   out_valid  holding register contains a word
//   out_data   held word
//   overrun    1-cycle pulse: offered word was dropped
module deser_out_stage #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         overrun
);

  logic         valid_reg;
  logic [N-1:0] data_reg;
  logic         overrun_reg;
  logic         accept;

  // Room exists when empty, or when the held word leaves in this very cycle.
  assign accept = !valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= in_valid && !accept;
      if (in_valid && accept) begin
        data_reg  <= in_data;
        valid_reg <= 1'b1;
      end else if (out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/serial_deserializer.sv
// Receive end of the serial shift path: collects a framed bit stream into
// N-bit words and hands them to a parallel consumer via deser_out_stage.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   sin_valid  sin_data carries a bit this cycle
//   sin_data   serial bit
//   sin_start  current bit is bit 0 of a new word (only with sin_valid)
//   out_valid  out_data holds a completed word
//   out_data   completed word
//   out_ready  consumer accepts when out_valid && out_ready
//   overrun    1-cycle pulse: completed word dropped, holding reg full
//   frame_err  1-cycle pulse: sin_start arrived mid-word
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin_valid,
  input  logic         sin_data,
  input  logic         sin_start,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic         overrun,
  output logic         frame_err
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [N-1:0]  shift_reg, shift_next;
  logic [N-1:0]  shifted, loaded;
  logic          frame_err_reg, frame_err_next;
  logic          word_done;

  // shifted: current bit appended to the partial word.
  // loaded : current bit as the first bit of a fresh word, rest cleared so
  //          nothing from an aborted or reset word can leak through.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shifted = {sin_data, shift_reg[N-1:1]};
      assign loaded  = {sin_data, {(N-1){1'b0}}};
    end else begin : g_msb_first
      assign shifted = {shift_reg[N-2:0], sin_data};
      assign loaded  = {{(N-1){1'b0}}, sin_data};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    shift_next     = shift_reg;
    frame_err_next = 1'b0;
    word_done      = 1'b0;
    if (sin_valid) begin
      case (state_reg)
        S_IDLE: begin
          if (sin_start) begin
            shift_next = loaded;
            count_next = ONE;
            state_next = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (sin_start) begin
            // Restart on the new frame; the partial word is abandoned.
            frame_err_next = 1'b1;
            shift_next     = loaded;
            count_next     = ONE;
          end else if (count_reg == LAST) begin
            word_done  = 1'b1;
            shift_next = shifted;
            count_next = '0;
            state_next = S_IDLE;
          end else begin
            shift_next = shifted;
            count_next = count_reg + ONE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // The completed word goes straight from the shift logic into the holding
  // register on the capturing edge, giving one cycle of latency.
  deser_out_stage #(.N(N)) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (word_done),
    .in_data   (shift_next),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overrun   (overrun)
  );

  assign frame_err = frame_err_reg;

endmodule
